// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO register owner and sequencer for the MIPS multiply/divide group.
// Multiplies complete in one cycle here; divides run on an external divider,
// and this block captures the divider's quotient and remainder. While a
// divide is in flight, any HI/LO access or new mul/div/mt op is stalled.
module hilo_muldiv_ctrl #(
    parameter int DIV_LATENCY = 33,
    parameter int CNT_W       = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        mf_req,
    input  logic        mf_sel,
    output logic [31:0] mf_data,
    output logic        stall,
    output logic        busy,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic [31:0] div_quotient,
    input  logic [31:0] div_remainder
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_DIV_RUN = 1'b1;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    // Counter value on which the divider result is valid and gets captured.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_LATENCY);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic        op_needs_slot;
    logic        accept;
    logic        is_div_op;
    logic        mult_signed;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] product;

    // NONE and the reserved encoding never touch HI/LO, so they never stall.
    assign op_needs_slot = op_valid && (op != OP_NONE) && (op != OP_RSVD);

    assign busy   = (state_q == ST_DIV_RUN);
    assign stall  = busy && (mf_req || op_needs_slot);
    assign accept = op_valid && !busy;

    // A divide by zero is simply dropped: no launch, HI/LO untouched.
    assign is_div_op  = (op == OP_DIV) || (op == OP_DIVU);
    assign div_start  = accept && is_div_op && (rt_val != 32'd0);
    assign div_signed = (op == OP_DIV);
    assign div_a      = rs_val;
    assign div_b      = rt_val;

    // Reads see the registered value, so a same-cycle write is not visible yet.
    assign mf_data = mf_sel ? hi_q : lo_q;

    // One shared 64x64 multiplier: sign-extending for MULT makes the low 64
    // bits of the product equal the exact signed 64-bit result.
    assign mult_signed = (op == OP_MULT);
    assign mul_a   = {{32{mult_signed & rs_val[31]}}, rs_val};
    assign mul_b   = {{32{mult_signed & rt_val[31]}}, rt_val};
    assign product = mul_a * mul_b;

    // Next-state logic for the controller state, divide counter and HI/LO.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (state_q == ST_IDLE) begin
            if (accept) begin
                case (op)
                    OP_MULT, OP_MULTU: begin
                        hi_d = product[63:32];
                        lo_d = product[31:0];
                    end
                    OP_MTHI: hi_d = rs_val;
                    OP_MTLO: lo_d = rs_val;
                    OP_DIV, OP_DIVU: begin
                        if (div_start) begin
                            state_d = ST_DIV_RUN;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end else begin
            if (cnt_q == CNT_LAST) begin
                lo_d    = div_quotient;
                hi_d    = div_remainder;
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers; reset may land mid-divide and abandons it cleanly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Scoreboard bench for hilo_muldiv_ctrl. Stimulus pushes expected MF read
// data and expected divider launches into queues; a negedge monitor pops and
// compares whenever the DUT accepts a read or pulses div_start. The external
// divider is a behavioural stand-in whose outputs hold junk until just before
// the capture edge.
module tb_hilo_muldiv_ctrl;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        mf_req;
    logic        mf_sel;
    logic [31:0] mf_data;
    logic        stall;
    logic        busy;
    logic        div_start;
    logic        div_signed;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;

    int checks = 0;
    int errors = 0;

    logic [31:0] expQ[$];
    logic [64:0] divQ[$];

    hilo_muldiv_ctrl #(.DIV_LATENCY(33), .CNT_W(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .op_valid     (op_valid),
        .op           (op),
        .rs_val       (rs_val),
        .rt_val       (rt_val),
        .mf_req       (mf_req),
        .mf_sel       (mf_sel),
        .mf_data      (mf_data),
        .stall        (stall),
        .busy         (busy),
        .div_start    (div_start),
        .div_signed   (div_signed),
        .div_a        (div_a),
        .div_b        (div_b),
        .div_quotient (div_quotient),
        .div_remainder(div_remainder)
    );

    always #5 clk = ~clk;

    // Divider stand-in: latches operands on the start edge and shows the
    // result only after edge 32, so an early capture picks up junk.
    logic        dvRun;
    logic [5:0]  dvEdge;
    logic [31:0] dvA;
    logic [31:0] dvB;
    logic        dvSigned;

    function automatic logic [63:0] divModel(input logic [31:0] a, input logic [31:0] b,
                                             input logic sgn);
        logic [31:0] q;
        logic [31:0] r;
        if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            dvRun         <= 1'b0;
            dvEdge        <= '0;
            dvA           <= '0;
            dvB           <= '0;
            dvSigned      <= 1'b0;
            div_quotient  <= 32'hDEADBEEF;
            div_remainder <= 32'hDEADBEEF;
        end else if (div_start) begin
            dvRun         <= 1'b1;
            dvEdge        <= '0;
            dvA           <= div_a;
            dvB           <= div_b;
            dvSigned      <= div_signed;
            div_quotient  <= 32'hDEADBEEF;
            div_remainder <= 32'hDEADBEEF;
        end else if (dvRun) begin
            dvEdge <= dvEdge + 6'd1;
            if (dvEdge + 6'd1 == 6'd32) begin
                dvRun <= 1'b0;
                {div_quotient, div_remainder} <= divModel(dvA, dvB, dvSigned);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [64:0] actual,
                               input logic [64:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Monitor: compares accepted reads and divider launches against the queues.
    logic [31:0] popData;
    logic [64:0] popDiv;
    always @(negedge clk) begin
        if (!reset) begin
            if (mf_req && !stall) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected mf read", 65'(mf_data), 65'h1_0000_0000);
                end else begin
                    popData = expQ.pop_front();
                    checkOutput("mf_data", 65'(mf_data), 65'(popData));
                end
            end
            if (div_start) begin
                if (divQ.size() == 0) begin
                    checkOutput("unexpected div_start", {div_signed, div_a, div_b}, 65'h0);
                end else begin
                    popDiv = divQ.pop_front();
                    checkOutput("div launch {signed,a,b}", {div_signed, div_a, div_b}, popDiv);
                end
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic [2:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input logic mr, input logic ms);
        op_valid = v;
        op       = o;
        rs_val   = a;
        rt_val   = b;
        mf_req   = mr;
        mf_sel   = ms;
    endtask

    task automatic idle();
        applyStimulus(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    // Holds the current request until the DUT stops stalling, counting stalled
    // cycles; returns #1 after the edge on which the request was taken.
    task automatic waitAccept(input string name, output int n);
        bit done;
        n    = 0;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (!stall) done = 1'b1;
            else n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout: actual=stalled required=accept within 100 cycles", name);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic doOp(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic expStart, input logic expSigned,
                        input int expStall);
        int n;
        if (expStart) divQ.push_back({expSigned, a, b});
        applyStimulus(1'b1, o, a, b, 1'b0, 1'b0);
        waitAccept(name, n);
        checkOutput({name, " stall cycles"}, 65'(n), 65'(expStall));
        idle();
    endtask

    task automatic doRead(input string name, input logic sel, input logic [31:0] expected,
                          input int expStall);
        int n;
        expQ.push_back(expected);
        applyStimulus(1'b0, OP_NONE, 32'd0, 32'd0, 1'b1, sel);
        waitAccept(name, n);
        checkOutput({name, " stall cycles"}, 65'(n), 65'(expStall));
        idle();
    endtask

    // Safety net in case something wedges outside the bounded waits.
    initial begin
        #50000;
        $display("[TB] FAIL watchdog: actual=still running required=finished");
        $fatal(1);
    end

    // Directed stimulus sequence.
    initial begin
        reset = 1'b1;
        idle();
        repeat (3) @(negedge clk);
        checkOutput("reset busy", 65'(busy), 65'd0);
        checkOutput("reset stall", 65'(stall), 65'd0);
        checkOutput("reset div_start", 65'(div_start), 65'd0);
        checkOutput("reset LO", 65'(mf_data), 65'd0);
        mf_sel = 1'b1;
        #1;
        checkOutput("reset HI", 65'(mf_data), 65'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle();

        $display("[TB] signed and unsigned multiplies");
        doOp("mult -3*4", OP_MULT, 32'hFFFFFFFD, 32'd4, 1'b0, 1'b0, 0);
        doRead("mult -3*4 hi", 1'b1, 32'hFFFFFFFF, 0);
        doRead("mult -3*4 lo", 1'b0, 32'hFFFFFFF4, 0);
        doOp("mult min*1", OP_MULT, 32'h80000000, 32'd1, 1'b0, 1'b0, 0);
        doRead("mult min*1 hi", 1'b1, 32'hFFFFFFFF, 0);
        doRead("mult min*1 lo", 1'b0, 32'h80000000, 0);
        doOp("multu", OP_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0, 0);
        doRead("multu hi", 1'b1, 32'h00000001, 0);
        doRead("multu lo", 1'b0, 32'hFFFFFFFE, 0);

        $display("[TB] read and MTLO in the same cycle");
        expQ.push_back(32'hFFFFFFFE);
        applyStimulus(1'b1, OP_MTLO, 32'hAAAA5555, 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("mtlo+read stall", 65'(stall), 65'd0);
        @(posedge clk);
        #1;
        idle();
        doRead("mtlo lo", 1'b0, 32'hAAAA5555, 0);
        doRead("mtlo hi untouched", 1'b1, 32'h00000001, 0);

        $display("[TB] signed divide with read behind it");
        doOp("div 7/-2", OP_DIV, 32'd7, 32'hFFFFFFFE, 1'b1, 1'b1, 0);
        checkOutput("div busy", 65'(busy), 65'd1);
        doRead("div lo", 1'b0, 32'hFFFFFFFD, 33);
        doRead("div hi", 1'b1, 32'h00000001, 0);

        $display("[TB] unsigned divide with MTHI behind it");
        doOp("divu 100/7", OP_DIVU, 32'd100, 32'd7, 1'b1, 1'b0, 0);
        doOp("mthi after divu", OP_MTHI, 32'h55, 32'd0, 1'b0, 1'b0, 33);
        doRead("divu hi", 1'b1, 32'h00000055, 0);
        doRead("divu lo", 1'b0, 32'd14, 0);

        $display("[TB] divide by zero");
        doOp("preload hi", OP_MTHI, 32'h12, 32'd0, 1'b0, 1'b0, 0);
        doOp("preload lo", OP_MTLO, 32'h34, 32'd0, 1'b0, 1'b0, 0);
        doOp("div by zero", OP_DIV, 32'd99, 32'd0, 1'b0, 1'b0, 0);
        checkOutput("div by zero busy", 65'(busy), 65'd0);
        doRead("div by zero hi", 1'b1, 32'h12, 0);
        doRead("div by zero lo", 1'b0, 32'h34, 0);

        $display("[TB] NONE and reserved ops during a divide");
        doOp("divu 9/2", OP_DIVU, 32'd9, 32'd2, 1'b1, 1'b0, 0);
        doOp("none while busy", OP_NONE, 32'hFFFF, 32'hFFFF, 1'b0, 1'b0, 0);
        doOp("reserved while busy", OP_RSVD, 32'hFFFF, 32'hFFFF, 1'b0, 1'b0, 0);
        doRead("divu 9/2 lo", 1'b0, 32'd4, 31);
        doRead("divu 9/2 hi", 1'b1, 32'd1, 0);

        $display("[TB] reset in the middle of a divide");
        doOp("divu long", OP_DIVU, 32'hFFFFFFFF, 32'd3, 1'b1, 1'b0, 0);
        repeat (9) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("mid-divide reset busy", 65'(busy), 65'd0);
        checkOutput("mid-divide reset LO", 65'(mf_data), 65'd0);
        mf_sel = 1'b1;
        #1;
        checkOutput("mid-divide reset HI", 65'(mf_data), 65'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle();
        doRead("post-reset lo", 1'b0, 32'd0, 0);
        doRead("post-reset hi", 1'b1, 32'd0, 0);

        repeat (2) @(posedge clk);
        checkOutput("unconsumed mf expectations", 65'(expQ.size()), 65'd0);
        checkOutput("unconsumed div launches", 65'(divQ.size()), 65'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
